// File: rtl/dma_pkg.sv
// Shared definitions for the DMA descriptor sequencer: DMA register map,
// sequencer register offsets, FSM states and the descriptor record.
package dma_pkg;

    localparam logic [15:0] DMA_CTRL      = 16'h0100;
    localparam logic [15:0] DMA_SRCL      = 16'h0101;
    localparam logic [15:0] DMA_SRCM      = 16'h0102;
    localparam logic [15:0] DMA_DSTL      = 16'h0103;
    localparam logic [15:0] DMA_DSTM      = 16'h0104;
    localparam logic [15:0] DMA_NUM       = 16'h0105;
    localparam logic [15:0] DMA_NULL_ADDR = 16'h0000;
    localparam logic [7:0]  DMA_START_VAL = 8'hFF;
    localparam logic [7:0]  PUSH_KEY      = 8'hFF;

    localparam logic [15:0] OFS_SRCL   = 16'd0;
    localparam logic [15:0] OFS_SRCM   = 16'd1;
    localparam logic [15:0] OFS_DSTL   = 16'd2;
    localparam logic [15:0] OFS_DSTM   = 16'd3;
    localparam logic [15:0] OFS_NUM    = 16'd4;
    localparam logic [15:0] OFS_PUSH   = 16'd5;
    localparam logic [15:0] OFS_STATUS = 16'd6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_SRCL,
        S_LD_SRCM,
        S_LD_DSTL,
        S_LD_DSTM,
        S_LD_NUM,
        S_START,
        S_WAIT,
        S_ACK
    } seq_state_e;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [7:0]  num;
    } desc_t;

    function automatic logic [2:0] sat_cnt(input logic [7:0] c);
        return (c > 8'd7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Descriptor FIFO for the DMA sequencer; head is visible combinationally and
// a push into a full FIFO is accepted when a pop happens in the same cycle.
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  desc_t                          din,
    output desc_t                          dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(QDEPTH+1)-1:0]    count
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    desc_t         mem [QDEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(QDEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dma_sequencer.sv
// Descriptor-queue front end for the single-channel DMA engine.
// Define DMA_SEQ_PERDESC_IRQ_EN to raise irq on every completed descriptor.
module dma_sequencer
    import dma_pkg::*;
#(
    parameter int unsigned QDEPTH = 4,
    parameter logic [15:0] BASE   = 16'h0110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_auxdaddr,
    input  logic [7:0]  cpu_auxdin,
    input  logic        cpu_ack,
    output logic        auxdoutsel,
    output logic [7:0]  auxdout,
    output logic [15:0] dma_auxdaddr,
    output logic [7:0]  dma_auxdin,
    input  logic        dma_irq,
    output logic        dma_ack,
    output logic        irq,
    output logic        busy
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    localparam logic [15:0] ADDR_SRCL   = BASE + OFS_SRCL;
    localparam logic [15:0] ADDR_SRCM   = BASE + OFS_SRCM;
    localparam logic [15:0] ADDR_DSTL   = BASE + OFS_DSTL;
    localparam logic [15:0] ADDR_DSTM   = BASE + OFS_DSTM;
    localparam logic [15:0] ADDR_NUM    = BASE + OFS_NUM;
    localparam logic [15:0] ADDR_PUSH   = BASE + OFS_PUSH;
    localparam logic [15:0] ADDR_STATUS = BASE + OFS_STATUS;

    seq_state_e    state_q, state_d;
    desc_t         stage_q, head;
    logic          push_prev_q, push_match, push_req;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [7:0]    cnt_ext;
    logic          more;
    logic          irq_q, irq_set;
    logic          ovf_q;

    assign push_match = (cpu_auxdaddr == ADDR_PUSH) && (cpu_auxdin == PUSH_KEY);
    assign push_req   = push_match && !push_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q     <= '0;
            push_prev_q <= 1'b0;
        end else begin
            push_prev_q <= push_match;
            if (cpu_auxdaddr == ADDR_SRCL) stage_q.src[7:0]  <= cpu_auxdin;
            if (cpu_auxdaddr == ADDR_SRCM) stage_q.src[15:8] <= cpu_auxdin;
            if (cpu_auxdaddr == ADDR_DSTL) stage_q.dst[7:0]  <= cpu_auxdin;
            if (cpu_auxdaddr == ADDR_DSTM) stage_q.dst[15:8] <= cpu_auxdin;
            if (cpu_auxdaddr == ADDR_NUM)  stage_q.num       <= cpu_auxdin;
        end
    end

    dma_desc_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (stage_q),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign cnt_ext = 8'(fifo_cnt);
    // In ACK the head is being popped: work remains if another entry is
    // queued behind it or a push lands in this same cycle.
    assign more    = (cnt_ext > 8'd1) || push_req;

    always_comb begin
        state_d      = state_q;
        dma_auxdaddr = cpu_auxdaddr;
        dma_auxdin   = cpu_auxdin;
        dma_ack      = 1'b0;
        fifo_pop     = 1'b0;
        irq_set      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_LD_SRCL;
            end
            S_LD_SRCL: begin
                dma_auxdaddr = DMA_SRCL;
                dma_auxdin   = head.src[7:0];
                state_d      = S_LD_SRCM;
            end
            S_LD_SRCM: begin
                dma_auxdaddr = DMA_SRCM;
                dma_auxdin   = head.src[15:8];
                state_d      = S_LD_DSTL;
            end
            S_LD_DSTL: begin
                dma_auxdaddr = DMA_DSTL;
                dma_auxdin   = head.dst[7:0];
                state_d      = S_LD_DSTM;
            end
            S_LD_DSTM: begin
                dma_auxdaddr = DMA_DSTM;
                dma_auxdin   = head.dst[15:8];
                state_d      = S_LD_NUM;
            end
            S_LD_NUM: begin
                dma_auxdaddr = DMA_NUM;
                dma_auxdin   = head.num;
                state_d      = S_START;
            end
            S_START: begin
                dma_auxdaddr = DMA_CTRL;
                dma_auxdin   = DMA_START_VAL;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                dma_auxdaddr = DMA_NULL_ADDR;
                dma_auxdin   = 8'h00;
                if (dma_irq) state_d = S_ACK;
            end
            S_ACK: begin
                dma_auxdaddr = DMA_NULL_ADDR;
                dma_auxdin   = 8'h00;
                dma_ack      = 1'b1;
                fifo_pop     = 1'b1;
                state_d      = more ? S_LD_SRCL : S_IDLE;
`ifdef DMA_SEQ_PERDESC_IRQ_EN
                irq_set      = 1'b1;
`else
                irq_set      = !more;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (irq_set)      irq_q <= 1'b1;
            else if (cpu_ack) irq_q <= 1'b0;
            if (push_req && fifo_full && !fifo_pop) ovf_q <= 1'b1;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign irq        = irq_q;
    assign auxdoutsel = (cpu_auxdaddr == ADDR_STATUS);
    assign auxdout    = auxdoutsel
                      ? {busy, fifo_full, fifo_empty, irq_q, ovf_q, sat_cnt(cnt_ext)}
                      : 8'h00;

endmodule
